// File: rtl/sdc_reader.sv
// sdc_reader: SPI-mode SD card block reader issuing CMD17 per block and streaming data bytes to RAM.
module sdc_reader #(
  parameter int BLOCK_BYTES   = 512,
  parameter int RESP_TIMEOUT  = 8,
  parameter int TOKEN_TIMEOUT = 4095
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] blockAddr,
  input  logic [7:0]  numBlocks,
  input  logic        dataFromSdc,
  input  logic        full,
  output logic        dataToSdc,
  output logic        sclkEn,
  output logic        csN,
  output logic [7:0]  dataToRam,
  output logic        byteValid,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  errCode
);
  typedef enum logic [3:0] {IDLE, CMD, RESP, TOKEN, DATA, CRC, GAP, DONE, ERR} stateT;
  localparam logic [15:0] RESP_LAST  = 16'(RESP_TIMEOUT * 8 - 1);
  localparam logic [15:0] TOKEN_LAST = 16'(TOKEN_TIMEOUT);
  localparam logic [15:0] DATA_LAST  = 16'(BLOCK_BYTES - 1);
  stateT state, stateNext;
  logic [47:0] frame;
  logic [31:0] addr;
  logic [7:0]  blocksLeft, rxByte;
  logic [6:0]  shifter;
  logic [5:0]  bitCnt;
  logic [15:0] cnt;
  logic [1:0]  errNext;
  logic        hunting, pend, active, byteEnd;
  assign active    = state inside {CMD, RESP, TOKEN, DATA, CRC};
  assign csN       = !active;
  // a received byte waiting on a full RAM freezes the bit clock at the byte boundary
  assign sclkEn    = (active || state == GAP) && !(pend && full);
  assign dataToSdc = (state == CMD) ? frame[47] : 1'b1;
  assign busy      = active || state == GAP;
  assign done      = state == DONE;
  assign byteValid = pend && !full;
  assign rxByte    = {shifter, dataFromSdc};
  assign byteEnd   = sclkEn && bitCnt == 6'd7;
  always_comb begin
    stateNext = state;
    errNext = 2'd0;
    case (state)
      IDLE: stateNext = start ? CMD : IDLE;
      CMD: stateNext = (bitCnt == 6'd47) ? RESP : CMD;
      RESP:
        if (hunting) errNext = (dataFromSdc && cnt == RESP_LAST) ? 2'd2 : 2'd0;
        else if (bitCnt == 6'd7) begin
          stateNext = TOKEN;
          errNext = (rxByte == 8'h00) ? 2'd0 : 2'd1;
        end
      TOKEN:
        if (bitCnt == 6'd7) begin
          stateNext = (rxByte == 8'hFE) ? DATA : TOKEN;
          errNext = (rxByte[7:4] == 4'h0) ? 2'd3 :
                    (rxByte != 8'hFE && cnt == TOKEN_LAST) ? 2'd2 : 2'd0;
        end
      DATA: stateNext = (byteEnd && cnt == DATA_LAST) ? CRC : DATA;
      CRC: stateNext = (sclkEn && bitCnt == 6'd15) ? GAP : CRC;
      GAP: stateNext = (bitCnt == 6'd7) ? ((blocksLeft == 8'd1) ? DONE : CMD) : GAP;
      default: stateNext = IDLE;
    endcase
    if (errNext != 2'd0) stateNext = ERR;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      frame      <= '1;
      addr       <= 32'd0;
      blocksLeft <= 8'd0;
      shifter    <= 7'd0;
      bitCnt     <= 6'd0;
      cnt        <= 16'd0;
      hunting    <= 1'b1;
      pend       <= 1'b0;
      dataToRam  <= 8'd0;
      error      <= 1'b0;
      errCode    <= 2'd0;
    end else begin
      state <= stateNext;
      if (byteValid) pend <= 1'b0;
      case (state)
        IDLE:
          if (start) begin
            addr       <= blockAddr;
            frame      <= {8'h51, blockAddr, 8'hFF};
            blocksLeft <= (numBlocks == 8'd0) ? 8'd1 : numBlocks;
            error      <= 1'b0;
            errCode    <= 2'd0;
          end
        CMD: begin
          frame  <= {frame[46:0], 1'b1};
          bitCnt <= bitCnt + 6'd1;
        end
        RESP:
          if (hunting) begin
            hunting <= dataFromSdc;
            bitCnt  <= dataFromSdc ? 6'd0 : 6'd1;
            cnt     <= cnt + 16'd1;
            shifter <= 7'd0;
          end else begin
            shifter <= rxByte[6:0];
            bitCnt  <= bitCnt + 6'd1;
          end
        TOKEN: begin
          shifter <= rxByte[6:0];
          bitCnt  <= (bitCnt == 6'd7) ? 6'd0 : bitCnt + 6'd1;
          if (bitCnt == 6'd7) cnt <= cnt + 16'd1;
        end
        DATA:
          if (sclkEn) begin
            shifter <= rxByte[6:0];
            bitCnt  <= byteEnd ? 6'd0 : bitCnt + 6'd1;
            if (byteEnd) begin
              dataToRam <= rxByte;
              pend      <= 1'b1;
              cnt       <= cnt + 16'd1;
            end
          end
        CRC: if (sclkEn) bitCnt <= bitCnt + 6'd1;
        GAP: begin
          bitCnt <= bitCnt + 6'd1;
          if (bitCnt == 6'd7) begin
            addr       <= addr + 32'd1;
            frame      <= {8'h51, addr + 32'd1, 8'hFF};
            blocksLeft <= blocksLeft - 8'd1;
          end
        end
        default: ;
      endcase
      if (stateNext == ERR) begin
        error   <= 1'b1;
        errCode <= errNext;
      end
      if (stateNext != state) begin
        bitCnt  <= 6'd0;
        cnt     <= 16'd0;
        hunting <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_sdc_reader.sv
// tb_sdc_reader: scoreboard bench for sdc_reader driven by a bit-level SPI card model.
module tb_sdc_reader;
  localparam logic [16:0] IDLE_OUTS = 17'h18000;
  logic        clk = 1'b0, reset = 1'b1, start = 1'b0, dataFromSdc = 1'b1, full = 1'b0;
  logic [31:0] blockAddr = 32'd0;
  logic [7:0]  numBlocks = 8'd0;
  logic        dataToSdc, sclkEn, csN, byteValid, busy, done, error;
  logic [7:0]  dataToRam, expByte;
  logic [1:0]  errCode;
  logic        misoQ[$];
  logic [7:0]  expQ[$];
  logic [47:0] cmdQ[$];
  logic [47:0] cmdShift = 48'd0, expCmd;
  logic        shiftNext = 1'b0;
  int nChecks = 0, nFails = 0, expLow = 0;
  int rxCount = 0, doneCount = 0, lowCount = 0, stallCount = 0, gapRun = 0, gapCount = 0, cmdPos = 0;

  sdc_reader dut (
    .clk(clk), .reset(reset), .start(start), .blockAddr(blockAddr), .numBlocks(numBlocks),
    .dataFromSdc(dataFromSdc), .full(full), .dataToSdc(dataToSdc), .sclkEn(sclkEn), .csN(csN),
    .dataToRam(dataToRam), .byteValid(byteValid), .busy(busy), .done(done), .error(error),
    .errCode(errCode)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [16:0] outs();
    return {dataToSdc, csN, sclkEn, byteValid, busy, done, error, errCode, dataToRam};
  endfunction

  // card: presents the queue head on MISO, advances after each clocked bit
  always @(posedge clk) begin
    #1;
    if (shiftNext && misoQ.size() != 0) void'(misoQ.pop_front());
    dataFromSdc = (misoQ.size() != 0) ? misoQ[0] : 1'b1;
  end

  always @(negedge clk) begin
    shiftNext = sclkEn;
    if (done) doneCount++;
    if (!csN) lowCount++;
    if (!csN && !sclkEn) stallCount++;
    if (byteValid) begin
      if (expQ.size() == 0) check("byteDue", 64'(expQ.size()), 64'd1);
      else begin
        expByte = expQ.pop_front();
        check("dataByte", 64'(dataToRam), 64'(expByte));
      end
      rxCount++;
    end
    if (csN) cmdPos = 0;
    else if (sclkEn && cmdPos < 48) begin
      cmdShift = {cmdShift[46:0], dataToSdc};
      cmdPos++;
      if (cmdPos == 48) begin
        expCmd = (cmdQ.size() != 0) ? cmdQ[0] : 48'd0;
        if (cmdQ.size() != 0) void'(cmdQ.pop_front());
        check("cmdFrame", 64'(cmdShift), 64'(expCmd));
      end
    end
    if (csN && sclkEn) gapRun++;
    else if (gapRun != 0) begin
      check("gapLen", 64'(gapRun), 64'd8);
      gapCount++;
      gapRun = 0;
    end
  end

  task automatic pushOnes(input int n);
    repeat (n) misoQ.push_back(1'b1);
  endtask

  task automatic pushByte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) misoQ.push_back(b[i]);
  endtask

  task automatic loadBlock(input logic [31:0] a, input int r1Gap, input logic [7:0] r1, input int tokGap,
                           input logic [7:0] filler, input logic [7:0] tok, input logic [7:0] seed);
    logic [7:0] d;
    cmdQ.push_back({8'h51, a, 8'hFF});
    pushOnes(48 + r1Gap);
    pushByte(r1);
    if (r1 == 8'h00) begin
      repeat (tokGap) pushByte(filler);
      pushByte(tok);
      if (tok == 8'hFE) begin
        for (int i = 0; i < 512; i++) begin
          d = 8'(i) + seed;
          pushByte(d);
          expQ.push_back(d);
        end
        pushByte(8'hAB);
        pushByte(8'hCD);
        pushOnes(8);
        expLow += 48 + r1Gap + 8 + tokGap * 8 + 8 + 512 * 8 + 16;
      end
    end
  endtask

  task automatic runRead(input logic [31:0] a, input logic [7:0] n);
    rxCount = 0; doneCount = 0; lowCount = 0; stallCount = 0; gapCount = 0;
    @(posedge clk); #1;
    blockAddr = a; numBlocks = n; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("errClear", 64'(error), 64'd0);
    check("busyRise", 64'(busy), 64'd1);
  endtask

  task automatic waitIdle(input int budget);
    int c = 0;
    while (busy && c < budget) begin
      @(posedge clk); #1;
      c++;
    end
    check("finishInBudget", 64'(busy), 64'd0);
  endtask

  task automatic waitBytes(input int n, input int budget);
    int c = 0;
    while (rxCount < n && c < budget) begin
      @(posedge clk); #1;
      c++;
    end
    check("reachByte", 64'(rxCount), 64'(n));
  endtask

  task automatic endRead(input logic e, input logic [1:0] code, input int bytes, input int gaps, input int low);
    check("errorFlag", 64'(error), 64'(e));
    check("errCode", 64'(errCode), 64'(code));
    check("idleLines", 64'({csN, sclkEn, dataToSdc}), 64'(3'b101));
    repeat (3) begin @(posedge clk); #1; end
    check("errorHeld", 64'(error), 64'(e));
    check("doneCount", 64'(doneCount), 64'(e ? 0 : 1));
    check("byteCount", 64'(rxCount), 64'(bytes));
    check("gapCount", 64'(gapCount), 64'(gaps));
    check("csLowCycles", 64'(lowCount), 64'(low));
    check("leftoverBytes", 64'(expQ.size()), 64'd0);
    check("leftoverCmds", 64'(cmdQ.size()), 64'd0);
    misoQ.delete(); expQ.delete(); cmdQ.delete();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("resetOuts", 64'(outs()), 64'(IDLE_OUTS));
    @(posedge clk); #1;
    reset = 1'b0;

    expLow = 0;
    loadBlock(32'h0000_0010, 16, 8'h00, 3, 8'hFF, 8'hFE, 8'd0);
    runRead(32'h0000_0010, 8'd1);
    waitIdle(6000);
    endRead(1'b0, 2'd0, 512, 1, expLow);

    loadBlock(32'h0000_0020, 5, 8'h04, 0, 8'hFF, 8'hFF, 8'd0);
    runRead(32'h0000_0020, 8'd1);
    waitIdle(500);
    endRead(1'b1, 2'd1, 0, 0, 61);

    cmdQ.push_back({8'h51, 32'h0000_0030, 8'hFF});
    pushOnes(48);
    runRead(32'h0000_0030, 8'd1);
    waitIdle(500);
    endRead(1'b1, 2'd2, 0, 0, 112);

    loadBlock(32'h0000_0040, 0, 8'h00, 2, 8'h3C, 8'h08, 8'd0);
    runRead(32'h0000_0040, 8'd1);
    waitIdle(500);
    endRead(1'b1, 2'd3, 0, 0, 80);

    loadBlock(32'h0000_0050, 0, 8'h00, 0, 8'hFF, 8'hFF, 8'd0);
    runRead(32'h0000_0050, 8'd1);
    waitIdle(34000);
    endRead(1'b1, 2'd2, 0, 0, 32824);

    expLow = 0;
    loadBlock(32'h1234_5678, 16, 8'h00, 3, 8'hFF, 8'hFE, 8'd3);
    runRead(32'h1234_5678, 8'd0);
    repeat (10) begin @(posedge clk); #1; end
    blockAddr = 32'hDEAD_BEEF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    waitBytes(100, 6000);
    full = 1'b1;
    repeat (20) begin @(posedge clk); #1; end
    full = 1'b0;
    waitIdle(6000);
    check("stallCycles", 64'(stallCount), 64'd13);
    endRead(1'b0, 2'd0, 512, 1, expLow + 13);

    expLow = 0;
    for (int k = 0; k < 3; k++)
      loadBlock(32'hFFFF_FFFF + 32'(k), 3 + k, 8'h00, k, 8'hFF, 8'hFE, 8'(7 * k));
    runRead(32'hFFFF_FFFF, 8'd3);
    waitIdle(14000);
    endRead(1'b0, 2'd0, 1536, 3, expLow);

    loadBlock(32'h0000_0077, 4, 8'h00, 1, 8'hFF, 8'hFE, 8'd0);
    runRead(32'h0000_0077, 8'd1);
    waitBytes(50, 3000);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("resetMidData", 64'(outs()), 64'(IDLE_OUTS));
    @(posedge clk); #1;
    reset = 1'b0;
    misoQ.delete(); expQ.delete(); cmdQ.delete();
    repeat (20) begin @(posedge clk); #1; end
    check("noDoneAfterReset", 64'(doneCount), 64'd0);
    check("idleAfterReset", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
